// File: rtl/ss_conv_ctrl_pkg.sv
// Shared types and defaults for the single-slope conversion controller.
// The default pulse latency matches the fixed latency of the upstream comparator edge sampler.
package ss_conv_ctrl_pkg;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_PULSE_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RAMP   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic ramp_rst;
    logic ramp_en;
    logic busy;
    logic valid;
  } ctrl_out_t;

  // Control outputs are a pure function of the state being entered, so they can be registered.
  function automatic ctrl_out_t decode_outputs(state_e s);
    ctrl_out_t o;
    o.ramp_rst = (s != ST_RAMP);
    o.ramp_en  = (s == ST_RAMP);
    o.busy     = (s == ST_SETTLE) || (s == ST_RAMP);
    o.valid    = (s == ST_DONE);
    return o;
  endfunction

endpackage

// File: rtl/ss_conv_ctrl_if.sv
// Conversion handshake between the controller and its environment (sampler, ramp DAC, readout).
// master drives start/comp_pulse; slave is the controller.
interface ss_conv_ctrl_if
  import ss_conv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic             comp_pulse;
  logic             ramp_rst;
  logic             ramp_en;
  logic [WIDTH-1:0] ramp_code;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             overflow;

  modport master (
    output start, comp_pulse,
    input  ramp_rst, ramp_en, ramp_code, busy, valid, data, overflow
  );

  modport slave (
    input  start, comp_pulse,
    output ramp_rst, ramp_en, ramp_code, busy, valid, data, overflow
  );

endinterface

// File: rtl/ss_conv_ctrl_ramp_counter.sv
// Ramp code counter: synchronous clear (priority), count enable and terminal-count flag.
// Holds at all-ones is the caller's job; the controller leaves RAMP on terminal count.
module ss_conv_ctrl_ramp_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: default assignment first so every path through the block drives count_d; no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '1);

endmodule

// File: rtl/ss_conv_ctrl.sv
// Single-slope conversion controller: settle, ramp, capture on comparator pulse with
// sampler-latency compensation, then a one-cycle valid strobe with held data/overflow.
module ss_conv_ctrl
  import ss_conv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned PULSE_LATENCY = DEF_PULSE_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  ss_conv_ctrl_if.slave   bus
);

  localparam int unsigned      SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] LAT         = WIDTH'(PULSE_LATENCY);

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overflow_q, overflow_d;
  ctrl_out_t        out_q, out_d;

  logic [WIDTH-1:0] ramp_code;
  logic             ramp_tc;
  logic             cnt_clr;
  logic             cnt_en;

  // Counter restarts from zero on every RAMP entry and reads zero whenever not ramping.
  assign cnt_clr = (state_q != ST_RAMP) || (state_d != ST_RAMP);
  assign cnt_en  = (state_q == ST_RAMP);

  ss_conv_ctrl_ramp_counter #(
    .WIDTH (WIDTH)
  ) u_ramp_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (ramp_code),
    .tc    (ramp_tc)
  );

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    data_d     = data_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_RAMP;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_RAMP: begin
        // A pulse on the terminal code still wins over overflow.
        if (bus.comp_pulse) begin
          data_d     = (ramp_code >= LAT) ? (ramp_code - LAT) : '0;
          overflow_d = 1'b0;
          state_d    = ST_DONE;
        end else if (ramp_tc) begin
          data_d     = '1;
          overflow_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_d = decode_outputs(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      out_q      <= decode_outputs(ST_IDLE);
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      out_q      <= out_d;
    end
  end

  assign bus.ramp_rst  = out_q.ramp_rst;
  assign bus.ramp_en   = out_q.ramp_en;
  assign bus.busy      = out_q.busy;
  assign bus.valid     = out_q.valid;
  assign bus.ramp_code = ramp_code;
  assign bus.data      = data_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ss_conv_ctrl.sv
// Self-checking bench for ss_conv_ctrl: scoreboard of expected results, popped on each valid strobe.
module tb_ss_conv_ctrl;
  import ss_conv_ctrl_pkg::*;

  localparam int W = 8;
  localparam int S = 4;
  localparam int L = 2;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ss_conv_ctrl_if #(.WIDTH(W)) bus ();

  ss_conv_ctrl #(
    .WIDTH         (W),
    .SETTLE_CYCLES (S),
    .PULSE_LATENCY (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  result_t      sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic         prev_valid = 1'b0;
  logic [W-1:0] last_data = '0;
  logic         last_ovf  = 1'b0;

  function automatic result_t expect_pulse(int c);
    result_t r;
    r.data = (c >= L) ? W'(c - L) : '0;
    r.ovf  = 1'b0;
    return r;
  endfunction

  // Scoreboard monitor: every valid strobe must match the oldest expected result.
  always @(negedge clk) begin
    result_t e;
    if (rst === 1'b1 && bus.valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: got data=%0d ovf=%0b, required no strobe", bus.data, bus.overflow);
      end else begin
        e = sb.pop_front();
        if (bus.data !== e.data || bus.overflow !== e.ovf)
          $display("FAIL result: got data=%0d ovf=%0b, required data=%0d ovf=%0b",
                   bus.data, bus.overflow, e.data, e.ovf);
        else
          n_pass++;
      end
      n_checks++;
      if (prev_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ramp_rst !== 1'b1 ||
          bus.ramp_en !== 1'b0 || bus.ramp_code !== '0)
        $display("FAIL done_outputs: got prev_valid=%0b busy=%0b ramp_rst=%0b ramp_en=%0b code=%0d, required 0 0 1 0 0",
                 prev_valid, bus.busy, bus.ramp_rst, bus.ramp_en, bus.ramp_code);
      else
        n_pass++;
    end
    prev_valid = bus.valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_conv();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_code(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.ramp_en === 1'b1 && bus.ramp_code === W'(c)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_at(input int c);
    bit ok;
    wait_code(c, ok);
    n_checks++;
    if (!ok) begin
      $display("FAIL wait_code: ramp_code %0d never reached, got code=%0d", c, bus.ramp_code);
    end else begin
      n_pass++;
      sb.push_back(expect_pulse(c));
      last_data = expect_pulse(c).data;
      last_ovf  = 1'b0;
      bus.comp_pulse = 1'b1;
      @(negedge clk);
      bus.comp_pulse = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    else n_pass++;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.comp_pulse = 1'b0;
    tick(3);
    n_checks++;
    if ({bus.ramp_rst, bus.ramp_en, bus.busy, bus.valid, bus.overflow} !== 5'b10000 ||
        bus.ramp_code !== '0 || bus.data !== '0)
      $display("FAIL reset_state: got rst=%0b en=%0b busy=%0b valid=%0b ovf=%0b code=%0d data=%0d",
               bus.ramp_rst, bus.ramp_en, bus.busy, bus.valid, bus.overflow, bus.ramp_code, bus.data);
    else n_pass++;
    rst = 1'b1;
    tick(2);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ramp_rst !== 1'b1)
      $display("FAIL idle_after_reset: got busy=%0b ramp_rst=%0b, required 0 1", bus.busy, bus.ramp_rst);
    else n_pass++;
  endtask

  task automatic test_basic();
    int n_settle = 0;
    start_conv();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.ramp_rst !== 1'b1 || bus.ramp_en !== 1'b0)
      $display("FAIL start_busy: got busy=%0b ramp_rst=%0b ramp_en=%0b, required 1 1 0",
               bus.busy, bus.ramp_rst, bus.ramp_en);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (bus.ramp_en === 1'b1) break;
      if (bus.busy === 1'b1 && bus.ramp_rst === 1'b1) n_settle++;
      tick();
    end
    n_checks++;
    if (n_settle != S) $display("FAIL settle_len: got %0d cycles, required %0d", n_settle, S);
    else n_pass++;
    n_checks++;
    if (bus.ramp_code !== '0 || bus.ramp_rst !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL ramp_first: got code=%0d ramp_rst=%0b busy=%0b, required 0 0 1",
               bus.ramp_code, bus.ramp_rst, bus.busy);
    else n_pass++;
    pulse_at(50);
    drain();
    n_checks++;
    if (bus.data !== W'(48) || bus.overflow !== 1'b0)
      $display("FAIL data_held: got data=%0d ovf=%0b, required 48 0", bus.data, bus.overflow);
    else n_pass++;
  endtask

  task automatic test_early();
    start_conv();
    pulse_at(1);
    drain();
    n_checks++;
    if (bus.data !== '0 || bus.overflow !== 1'b0)
      $display("FAIL early_sat: got data=%0d ovf=%0b, required 0 0", bus.data, bus.overflow);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int idx = 0;
    bit seq_ok = 1'b1;
    result_t r;
    start_conv();
    for (int i = 0; i < 20; i++) begin
      if (bus.ramp_en === 1'b1) break;
      tick();
    end
    r.data = '1;
    r.ovf  = 1'b1;
    sb.push_back(r);
    last_data = r.data;
    last_ovf  = 1'b1;
    while (bus.ramp_en === 1'b1 && idx < 300) begin
      if (bus.ramp_code !== W'(idx)) seq_ok = 1'b0;
      idx++;
      tick();
    end
    n_checks++;
    if (!seq_ok) $display("FAIL ramp_sequence: code did not count 0..255 in order, got final code=%0d", bus.ramp_code);
    else n_pass++;
    n_checks++;
    if (idx != 256) $display("FAIL ramp_duration: got %0d cycles, required 256", idx);
    else n_pass++;
    drain();
  endtask

  task automatic test_coincident();
    start_conv();
    pulse_at(255);
    drain();
    n_checks++;
    if (bus.data !== W'(253) || bus.overflow !== 1'b0)
      $display("FAIL coincident: got data=%0d ovf=%0b, required 253 0", bus.data, bus.overflow);
    else n_pass++;
  endtask

  task automatic test_ignore();
    bit ok;
    bus.comp_pulse = 1'b1;
    tick(2);
    bus.comp_pulse = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.data !== last_data || bus.overflow !== last_ovf)
      $display("FAIL idle_pulse: got busy=%0b data=%0d ovf=%0b, required 0 %0d %0b",
               bus.busy, bus.data, bus.overflow, last_data, last_ovf);
    else n_pass++;
    bus.start = 1'b1;
    tick();
    bus.comp_pulse = 1'b1;
    tick();
    bus.comp_pulse = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.ramp_en !== 1'b0 || bus.data !== last_data)
      $display("FAIL settle_pulse: got busy=%0b ramp_en=%0b data=%0d, required 1 0 %0d",
               bus.busy, bus.ramp_en, bus.data, last_data);
    else n_pass++;
    pulse_at(30);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!ok) $display("FAIL wait_valid: valid never seen, got busy=%0b", bus.busy);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ramp_rst !== 1'b1)
      $display("FAIL idle_reentry: got busy=%0b ramp_rst=%0b, required 0 1", bus.busy, bus.ramp_rst);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.data !== W'(28))
      $display("FAIL restart_from_idle: got busy=%0b data=%0d, required 1 28", bus.busy, bus.data);
    else n_pass++;
    wait_code(5, ok);
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulse_at(40);
    drain();
    n_checks++;
    if (bus.data !== W'(38) || bus.busy !== 1'b0)
      $display("FAIL second_conv: got data=%0d busy=%0b, required 38 0", bus.data, bus.busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    start_conv();
    wait_code(100, ok);
    n_checks++;
    if (!ok) $display("FAIL abort_wait: code 100 never reached, got code=%0d", bus.ramp_code);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.ramp_rst, bus.ramp_en, bus.busy, bus.valid, bus.overflow} !== 5'b10000 ||
        bus.ramp_code !== '0 || bus.data !== '0)
      $display("FAIL abort_reset: got rst=%0b en=%0b busy=%0b valid=%0b ovf=%0b code=%0d data=%0d",
               bus.ramp_rst, bus.ramp_en, bus.busy, bus.valid, bus.overflow, bus.ramp_code, bus.data);
    else n_pass++;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.data !== '0)
      $display("FAIL abort_idle: got busy=%0b data=%0d, required 0 0", bus.busy, bus.data);
    else n_pass++;
    start_conv();
    pulse_at(20);
    drain();
    n_checks++;
    if (bus.data !== W'(18) || bus.overflow !== 1'b0)
      $display("FAIL post_abort: got data=%0d ovf=%0b, required 18 0", bus.data, bus.overflow);
    else n_pass++;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.comp_pulse = 1'b0;
    test_reset();
    test_basic();
    test_early();
    test_overflow();
    test_coincident();
    test_ignore();
    test_abort();
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ss_conv_ctrl.md
Name: ss_conv_ctrl

Overview:
Single-slope conversion controller sitting directly downstream of the comparator edge sampler. It resets and settles the ramp, runs a ramp code counter that drives the ramp DAC, and captures the count on the sampler's one-cycle comp_pulse. It compensates for the sampler's fixed pulse latency and presents the result with a one-cycle valid strobe to the readout/logging stage.

Parameters:
- WIDTH, 8, bit width of ramp code and result.
- SETTLE_CYCLES, 4, cycles ramp_rst is held after start before ramping (>=1).
- PULSE_LATENCY, 2, cycles from ramp code applied to comp_pulse seen; subtracted from captured count.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (asserted when 0 at posedge).
- start  in  1  conversion request; sampled only in IDLE.
- comp_pulse  in  1  one-cycle pulse from edge sampler.
- ramp_rst  out  1  holds ramp DAC/integrator at zero.
- ramp_en  out  1  high while ramp is advancing.
- ramp_code  out  WIDTH  current ramp code to DAC.
- busy  out  1  high in SETTLE and RAMP.
- valid  out  1  one-cycle result strobe.
- data  out  WIDTH  latched result; held until next capture.
- overflow  out  1  last conversion hit terminal count without a pulse; updated with valid.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, ramp_rst=1, ramp_en=0, ramp_code=0, busy=0, valid=0, data=0, overflow=0. Takes priority over all else, including mid-conversion; an aborted conversion never raises valid.
- IDLE: ramp_rst=1, ramp_en=0, ramp_code=0. start=1 at posedge -> SETTLE, settle counter cleared.
- SETTLE: busy=1, ramp_rst=1, ramp_code=0; lasts exactly SETTLE_CYCLES cycles, then -> RAMP.
- RAMP: busy=1, ramp_rst=0, ramp_en=1. First RAMP cycle ramp_code=0; it increments by 1 every posedge while in RAMP.
  - comp_pulse=1 at posedge with ramp_code=C: data <= (C >= PULSE_LATENCY) ? C-PULSE_LATENCY : 0; overflow <= 0; -> DONE.
  - ramp_code==2^WIDTH-1 and comp_pulse=0: data <= all ones; overflow <= 1; -> DONE. No wrap-around of ramp_code.
  - Pulse coincident with terminal count: pulse wins (overflow=0, data=C-PULSE_LATENCY).
- DONE: valid=1 for exactly this cycle, busy=0, ramp_rst=1, ramp_en=0, ramp_code=0; -> IDLE next posedge.
- Latency: start sampled at edge t0 -> busy first high after t0; RAMP first cycle begins after edge t0+SETTLE_CYCLES; valid high in the cycle after the capturing edge.
- start ignored while busy or in DONE (no queuing). comp_pulse ignored outside RAMP.
- data/overflow change only on a capture; valid is never high for two consecutive cycles.

Decomposition:
- Shared header/package (adc_pkg): state encoding localparams (IDLE, SETTLE, RAMP, DONE), default WIDTH, default PULSE_LATENCY matching the edge sampler's fixed latency.
- One sub-module: ramp_counter (WIDTH-bit counter with sync clear, enable, terminal-count flag). FSM, settle counter, latency subtraction and output regs stay in ss_conv_ctrl.

Test Plan (WIDTH=8, SETTLE_CYCLES=4, PULSE_LATENCY=2):
1. Release reset, one-cycle start, pulse when ramp_code=50 -> ramp_rst high 4 cycles after start, valid for exactly 1 cycle, data=48, overflow=0, busy falls with valid.
2. Early pulse at ramp_code=1 -> data=0 (saturated), overflow=0.
3. No pulse -> ramp_code counts 0..255 without wrap, then valid with data=255, overflow=1; total RAMP duration 256 cycles.
4. Pulse coincident with ramp_code=255 -> data=253, overflow=0.
5. start held high / re-pulsed during SETTLE and RAMP, plus comp_pulse during IDLE and SETTLE -> no extra conversions, no valid, data unchanged; the second conversion starts only after IDLE is re-entered.
6. rst=0 at ramp_code=100 -> next cycle all outputs at reset values, no valid; a subsequent start converts normally (e.g. pulse at 20 -> data=18).
